// File: rtl/hazard_stall_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, MULT/DIV occupancy tracking and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 4,
   parameter int unsigned DIV_CYCLES  = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  IF_ID_RegRs,
   input  logic [4:0]  IF_ID_RegRt,
   input  logic        IF_ID_UsesRt,
   input  logic [4:0]  ID_EX_RegRt,
   input  logic        ID_EX_MemRead,
   input  logic        EX_BranchTaken,
   input  logic        EX_MulDivStart,
   input  logic        EX_IsDiv,
   input  logic        ID_ReadsHiLo,
   input  logic        ID_IsMulDiv,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        ID_EX_Bubble,
   output logic        IF_ID_Flush,
   output logic        MulDivBusy,
   output logic        MulDivDone,
   output logic [15:0] StallCycles
);

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_e;

   localparam logic [5:0]  MULT_LOAD = 6'(MULT_CYCLES - 1);
   localparam logic [5:0]  DIV_LOAD  = 6'(DIV_CYCLES - 1);
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic md_hold;
   logic stall;
   logic md_done;

   // Register zero is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ID_EX_MemRead && (ID_EX_RegRt != 5'd0) &&
                     ((ID_EX_RegRt == IF_ID_RegRs) ||
                      (IF_ID_UsesRt && (ID_EX_RegRt == IF_ID_RegRt)));

   assign md_hold = (state_q == MD_BUSY) && (ID_ReadsHiLo || ID_IsMulDiv);

   // A taken branch squashes the ID instruction, so any stall it caused is moot.
   assign stall = (load_use || md_hold) && !EX_BranchTaken;

   assign PCWrite      = !stall;
   assign IF_ID_Write  = !stall;
   assign ID_EX_Bubble = stall || EX_BranchTaken;
   assign IF_ID_Flush  = EX_BranchTaken;
   assign MulDivBusy   = (state_q == MD_BUSY);
   assign MulDivDone   = md_done;
   assign StallCycles  = stall_cnt_q;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      md_done = 1'b0;
      unique case (state_q)
         RUN: begin
            // The MULT/DIV in EX is older than any branch beside it, so it always issues.
            if (EX_MulDivStart) begin
               state_d = MD_BUSY;
               cnt_d   = EX_IsDiv ? DIV_LOAD : MULT_LOAD;
            end
         end
         MD_BUSY: begin
            if (cnt_q == 6'd0) begin
               md_done = 1'b1;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = 6'd0;
         end
      endcase
   end

   assign stall_cnt_d = (stall && (stall_cnt_q != STALL_MAX)) ? stall_cnt_q + 16'd1
                                                              : stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q     <= RUN;
         cnt_q       <= 6'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
